histogram_accumulator: RTL and testbench
========================================

// Module: histogram_accumulator
// PURPOSE
//  Builds a 256-bin luminance histogram from the camera pixel stream, one frame at a time.
//  Ping-pong banks: one bank accumulates the current frame while the other serves reads to the histogram display stage.
//  Also supplies that stage with the frame's peak bin count (normalisation) and frame-done/overrun status.
// PARAMETERS
//  PIX_W   8    pixel/bin-address width; bins = 2**PIX_W
//  CNT_W   20   bin counter width; counts saturate at 2**CNT_W-1
// PORTS
//  iClk        in   1      system clock
//  iRst_n      in   1      asynchronous active-low reset
//  iValid      in   1      pixel qualifier
//  iPixel      in   PIX_W  pixel intensity = bin index
//  iFrameEnd   in   1      one-cycle pulse after last pixel of frame
//  iRdAddr     in   PIX_W  display read address (read bank)
//  oRdData     out  CNT_W  bin count of read bank at iRdAddr, 1-cycle latency
//  oMaxValue   out  CNT_W  largest bin of last completed frame
//  oFrameDone  out  1      one-cycle pulse when banks swap
//  oOverrun    out  1      sticky: pixel dropped while not in ACCUM
//  oThreshPoint out PIX_W  mean-intensity threshold (HISTO_MEAN_THRESH_EN only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0, bank select 0, state CLEAR, clear address 0, RMW pipeline empty.
//  FSM: CLEAR -> ACCUM -> DRAIN -> SWAP -> CLEAR.
//   CLEAR: write 0 to write-bank addr 0..2**PIX_W-1, one per cycle; ACCUM after last address. Running max <= 0.
//   ACCUM: every iValid pixel increments its bin; iFrameEnd -> DRAIN.
//   DRAIN: 2 cycles, lets RMW pipeline retire; pixels here dropped.
//   SWAP: 1 cycle; toggle bank select, oMaxValue <= running max, oFrameDone=1.
//  Pixels with iValid in CLEAR/DRAIN/SWAP are dropped and set oOverrun (cleared only by reset).
//  iFrameEnd outside ACCUM is ignored.
//  RMW pipeline (ACCUM): S0 read bin, S1 data returns, S2 write data+1.
//   Forwarding: if S1 or S2 holds same bin as incoming read, use in-flight value; back-to-back identical
//   pixels on every cycle must count exactly (N pixels -> +N).
//   Increment saturates at 2**CNT_W-1; running max updated from S2 write value.
//  Read port: read bank = bank select; registered 1-cycle latency; unaffected by accumulation.
//   Read data changes bank on the cycle after SWAP; no other glitches.
//  Reset mid-frame: histogram discarded, re-enters CLEAR; read bank contents undefined until first oFrameDone.
// CONFIGURATION
//  HISTO_MEAN_THRESH_EN defined: accumulate pixel sum (PIX_W+CNT_W bits) and pixel count per frame;
//   at SWAP start a sequential restoring divider (PIX_W+CNT_W cycles, during CLEAR of next frame);
//   oThreshPoint <= sum/count (truncated), updated when divide completes; count 0 -> keeps previous value.
//  Undefined: no sum/count/divider logic; oThreshPoint tied to 0 (display disables marker on 0).
// STRUCTURE
//  Shared package: state enum {CLEAR,ACCUM,DRAIN,SWAP}, PIX_W/CNT_W defaults, saturation constant.
//  Sub-module histo_bank_ram: 2**PIX_W x CNT_W simple dual-port sync RAM, instantiated twice.
//  Divider kept inline, inside HISTO_MEAN_THRESH_EN guard.
// TESTING
//  Reset, wait 256 cycles, 1000 pixels all value 7 back-to-back, iFrameEnd -> bin7=1000, others 0, oMaxValue=1000.
//  Alternating 3,3,4,3 every cycle x250 -> bin3=750, bin4=250 (forwarding correct).
//  Frame A (ramp 0..255 once), frame B (all 9 x5) -> after 2nd oFrameDone read bin9=5, bin200=0, oMaxValue=5.
//  Pixel asserted during CLEAR -> oOverrun=1 stays 1 after next frame; count unaffected.
//  2**20+5 pixels value 0 -> bin0=0xFFFFF, oMaxValue=0xFFFFF.
//  HISTO_MEAN_THRESH_EN: 100 px of 10 + 100 px of 30 -> oThreshPoint=20 after divide; undefined -> 0.

Source files
------------

// File: rtl/histogram_accumulator_pkg.sv
// Shared types and defaults for the luminance histogram accumulator.
package histogram_accumulator_pkg;

    // Default widths: pixel/bin-address width and bin counter width.
    localparam int unsigned HISTO_PIX_W = 8;
    localparam int unsigned HISTO_CNT_W = 20;

    // Bin counts stop at this value instead of wrapping (default counter width).
    localparam logic [HISTO_CNT_W-1:0] HISTO_CNT_SAT = {HISTO_CNT_W{1'b1}};

    // Frame-level control states.
    typedef enum logic [1:0] {
        StClear = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2,
        StSwap  = 2'd3
    } state_e;

    // Where the S1 stage takes its base count from.
    typedef enum logic [1:0] {
        FwdRam  = 2'd0,  // bank read data is current
        FwdS2   = 2'd1,  // previous pixel hit the same bin; take its S2 result
        FwdHold = 2'd2   // pixel two back hit the same bin; its write raced our read
    } fwd_e;

endpackage

// File: rtl/histogram_accumulator_if.sv
// Pixel stream in, display read port and status out for histogram_accumulator.
interface histogram_accumulator_if #(
    parameter int unsigned PIX_W = histogram_accumulator_pkg::HISTO_PIX_W,
    parameter int unsigned CNT_W = histogram_accumulator_pkg::HISTO_CNT_W
);
    logic             iValid;
    logic [PIX_W-1:0] iPixel;
    logic             iFrameEnd;
    logic [PIX_W-1:0] iRdAddr;
    logic [CNT_W-1:0] oRdData;
    logic [CNT_W-1:0] oMaxValue;
    logic             oFrameDone;
    logic             oOverrun;
    logic [PIX_W-1:0] oThreshPoint;

    // Camera / display side.
    modport master (
        output iValid, iPixel, iFrameEnd, iRdAddr,
        input  oRdData, oMaxValue, oFrameDone, oOverrun, oThreshPoint
    );

    // Histogram block side.
    modport slave (
        input  iValid, iPixel, iFrameEnd, iRdAddr,
        output oRdData, oMaxValue, oFrameDone, oOverrun, oThreshPoint
    );
endinterface

// File: rtl/histo_bank_ram.sv
// One histogram bank: simple dual-port synchronous RAM, registered read.
module histo_bank_ram
    import histogram_accumulator_pkg::*;
#(
    parameter int unsigned ADDR_W = HISTO_PIX_W,
    parameter int unsigned DATA_W = HISTO_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Write port; storage itself has no reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port returns old data on a same-cycle write to the same address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/histogram_accumulator.sv
// Ping-pong 2**PIX_W-bin luminance histogram with peak count and overrun status.
// Optional build macro HISTO_MEAN_THRESH_EN adds a per-frame mean (oThreshPoint).
module histogram_accumulator
    import histogram_accumulator_pkg::*;
#(
    parameter int unsigned PIX_W = HISTO_PIX_W,
    parameter int unsigned CNT_W = HISTO_CNT_W
) (
    input logic                    iClk,
    input logic                    iRst_n,
    histogram_accumulator_if.slave io_bus
);
    localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};

    state_e           r_state, w_state_nxt;
    logic             r_bank_sel;       // read bank; the other bank accumulates
    logic [PIX_W-1:0] r_clr_addr;
    logic             r_drain_cnt;
    logic             w_accept;

    logic             r_s1_vld;
    logic [PIX_W-1:0] r_s1_addr;
    fwd_e             r_s1_fwd;
    fwd_e             w_fwd_sel;
    logic [CNT_W-1:0] r_s1_hold;
    logic [CNT_W-1:0] w_s1_base, w_s1_inc;

    logic             r_s2_vld;
    logic [PIX_W-1:0] r_s2_addr;
    logic [CNT_W-1:0] r_s2_data;

    logic [CNT_W-1:0] r_run_max, r_max_value;
    logic             r_overrun;

    logic             w_wr_en;
    logic [PIX_W-1:0] w_waddr;
    logic [CNT_W-1:0] w_wdata;
    logic [PIX_W-1:0] w_bank_raddr [2];
    logic [CNT_W-1:0] w_bank_rdata [2];
    logic [CNT_W-1:0] w_acc_rdata;

    assign w_accept = io_bus.iValid && (r_state == StAccum);

    // Frame state register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next frame state: clear sweep, accumulate, drain RMW, swap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StClear: if (r_clr_addr == '1) w_state_nxt = StAccum;
            StAccum: if (io_bus.iFrameEnd) w_state_nxt = StDrain;
            StDrain: if (r_drain_cnt)      w_state_nxt = StSwap;
            StSwap:                        w_state_nxt = StClear;
            default:                       w_state_nxt = StClear;
        endcase
    end

    // Frame bookkeeping: clear address, drain count, bank select, status.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_clr_addr  <= '0;
            r_drain_cnt <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_max_value <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_clr_addr  <= (r_state == StClear) ? r_clr_addr + 1'b1 : '0;
            r_drain_cnt <= (r_state == StDrain) ? ~r_drain_cnt : 1'b0;
            if (r_state == StSwap) begin
                r_bank_sel  <= ~r_bank_sel;
                r_max_value <= r_run_max;
            end
            if (io_bus.iValid && (r_state != StAccum)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Forward decision at S0, against pixels still in flight.
    always_comb begin
        w_fwd_sel = FwdRam;
        if (r_s1_vld && (r_s1_addr == io_bus.iPixel)) begin
            w_fwd_sel = FwdS2;
        end else if (r_s2_vld && (r_s2_addr == io_bus.iPixel)) begin
            w_fwd_sel = FwdHold;
        end
    end

    assign w_acc_rdata = r_bank_sel ? w_bank_rdata[0] : w_bank_rdata[1];

    // S1 base count selection and saturating increment.
    always_comb begin
        w_s1_base = w_acc_rdata;
        case (r_s1_fwd)
            FwdS2:   w_s1_base = r_s2_data;
            FwdHold: w_s1_base = r_s1_hold;
            default: w_s1_base = w_acc_rdata;
        endcase
        w_s1_inc = (w_s1_base == CntSat) ? w_s1_base : w_s1_base + 1'b1;
    end

    // RMW pipeline registers and running peak.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_fwd  <= FwdRam;
            r_s1_hold <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
            r_run_max <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_addr <= io_bus.iPixel;
            r_s1_fwd  <= w_fwd_sel;
            r_s1_hold <= r_s2_data;
            r_s2_vld  <= r_s1_vld;
            r_s2_addr <= r_s1_addr;
            r_s2_data <= w_s1_inc;
            if (r_state == StClear) begin
                r_run_max <= '0;
            end else if (r_s2_vld && (r_s2_data > r_run_max)) begin
                r_run_max <= r_s2_data;
            end
        end
    end

    // Write-bank port: zero sweep while clearing, otherwise the S2 write-back.
    always_comb begin
        w_wr_en = r_s2_vld;
        w_waddr = r_s2_addr;
        w_wdata = r_s2_data;
        if (r_state == StClear) begin
            w_wr_en = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_wr;
        assign w_is_wr = (r_bank_sel != 1'(b));
        // Outside ACCUM both banks follow iRdAddr so the swap needs no extra cycle.
        assign w_bank_raddr[b] = (w_is_wr && (r_state == StAccum)) ? io_bus.iPixel
                                                                    : io_bus.iRdAddr;
        histo_bank_ram #(
            .ADDR_W (PIX_W),
            .DATA_W (CNT_W)
        ) u_ram (
            .i_clk   (iClk),
            .i_rst_n (iRst_n),
            .i_we    (w_wr_en && w_is_wr),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (w_bank_raddr[b]),
            .o_rdata (w_bank_rdata[b])
        );
    end

    assign io_bus.oRdData    = r_bank_sel ? w_bank_rdata[1] : w_bank_rdata[0];
    assign io_bus.oMaxValue  = r_max_value;
    assign io_bus.oFrameDone = (r_state == StSwap);
    assign io_bus.oOverrun   = r_overrun;

`ifdef HISTO_MEAN_THRESH_EN
    localparam int unsigned SumW    = PIX_W + CNT_W;
    localparam int unsigned DivCntW = $clog2(SumW + 1);

    logic [SumW-1:0]    r_sum;
    logic [CNT_W-1:0]   r_pcount;
    logic               r_div_busy;
    logic [DivCntW-1:0] r_div_cnt;
    logic [SumW-1:0]    r_div_quo;
    logic [CNT_W-1:0]   r_div_den;
    logic [CNT_W-1:0]   r_div_rem;
    logic [PIX_W-1:0]   r_thresh;
    logic [CNT_W:0]     w_rem_shift;
    logic [CNT_W-1:0]   w_rem_diff;
    logic               w_ge;

    // One restoring-division step: shift in next dividend bit, trial subtract.
    always_comb begin
        w_rem_shift = {r_div_rem, r_div_quo[SumW-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_div_den});
        w_rem_diff  = CNT_W'(w_rem_shift - {1'b0, r_div_den});
    end

    // Per-frame sum/count, divider launched at swap, runs during the next clear.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sum      <= '0;
            r_pcount   <= '0;
            r_div_busy <= 1'b0;
            r_div_cnt  <= '0;
            r_div_quo  <= '0;
            r_div_den  <= '0;
            r_div_rem  <= '0;
            r_thresh   <= '0;
        end else begin
            if (r_state == StSwap) begin
                r_sum    <= '0;
                r_pcount <= '0;
                if (r_pcount != '0) begin
                    r_div_busy <= 1'b1;
                    r_div_cnt  <= '0;
                    r_div_quo  <= r_sum;
                    r_div_den  <= r_pcount;
                    r_div_rem  <= '0;
                end
            end else if (w_accept) begin
                r_sum <= r_sum + SumW'(io_bus.iPixel);
                if (r_pcount != CntSat) begin
                    r_pcount <= r_pcount + 1'b1;
                end
            end
            if (r_div_busy) begin
                r_div_rem <= w_ge ? w_rem_diff : w_rem_shift[CNT_W-1:0];
                r_div_quo <= {r_div_quo[SumW-2:0], w_ge};
                r_div_cnt <= r_div_cnt + 1'b1;
                if (r_div_cnt == DivCntW'(SumW - 1)) begin
                    r_div_busy <= 1'b0;
                    r_thresh   <= {r_div_quo[PIX_W-2:0], w_ge};
                end
            end
        end
    end

    assign io_bus.oThreshPoint = r_thresh;
`else
    assign io_bus.oThreshPoint = '0;
`endif

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed self-checking bench for histogram_accumulator.
// A second instance with a 10-bit counter exercises saturation in few cycles.
module tb_histogram_accumulator;

    logic iClk;
    logic iRst_n;

    logic       tb_valid;
    logic [7:0] tb_pixel;
    logic       tb_frame_end;
    logic [7:0] tb_rd_addr;
    logic       sel_sat;

    logic [19:0] obs_rd_data;
    logic [19:0] obs_max;
    logic        obs_frame_done;

    int n_checks;
    int n_errors;

    histogram_accumulator_if #(.PIX_W(8), .CNT_W(20)) bus ();
    histogram_accumulator_if #(.PIX_W(8), .CNT_W(10)) bus_s ();

    histogram_accumulator #(.PIX_W(8), .CNT_W(20)) u_dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .io_bus (bus)
    );

    histogram_accumulator #(.PIX_W(8), .CNT_W(10)) u_dut_sat (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .io_bus (bus_s)
    );

    assign bus.iValid      = tb_valid && !sel_sat;
    assign bus.iPixel      = tb_pixel;
    assign bus.iFrameEnd   = tb_frame_end && !sel_sat;
    assign bus.iRdAddr     = tb_rd_addr;
    assign bus_s.iValid    = tb_valid && sel_sat;
    assign bus_s.iPixel    = tb_pixel;
    assign bus_s.iFrameEnd = tb_frame_end && sel_sat;
    assign bus_s.iRdAddr   = tb_rd_addr;

    always_comb begin
        obs_rd_data    = sel_sat ? 20'(bus_s.oRdData) : bus.oRdData;
        obs_max        = sel_sat ? 20'(bus_s.oMaxValue) : bus.oMaxValue;
        obs_frame_done = sel_sat ? bus_s.oFrameDone : bus.oFrameDone;
    end

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        tb_valid = 1'b1;
        tb_pixel = p;
        tick();
    endtask

    task automatic idle();
        tb_valid = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) push(p);
        idle();
    endtask

    task automatic check_bin(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        tb_rd_addr = addr;
        tick();
        check_eq(tag, 32'(obs_rd_data), exp);
    endtask

    // Pulse frame end, wait (bounded) for the swap, report read data around it.
    task automatic end_frame(input string tag, output logic [19:0] rd_at,
                             output logic [19:0] rd_after);
        logic seen;
        seen         = 1'b0;
        tb_frame_end = 1'b1;
        tick();
        tb_frame_end = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (obs_frame_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
        rd_at = obs_rd_data;
        tick();
        rd_after = obs_rd_data;
        check_eq($sformatf("%s_done_pulse", tag), 32'(obs_frame_done), 32'd0);
    endtask

    initial begin
        logic [19:0] rd_at;
        logic [19:0] rd_after;
        logic [7:0]  exp_thresh;

        n_checks     = 0;
        n_errors     = 0;
        iRst_n       = 1'b0;
        tb_valid     = 1'b0;
        tb_pixel     = '0;
        tb_frame_end = 1'b0;
        tb_rd_addr   = '0;
        sel_sat      = 1'b0;

        repeat (3) tick();
        check_eq("rst_rd_data", 32'(bus.oRdData), 32'd0);
        check_eq("rst_max", 32'(bus.oMaxValue), 32'd0);
        check_eq("rst_frame_done", 32'(bus.oFrameDone), 32'd0);
        check_eq("rst_overrun", 32'(bus.oOverrun), 32'd0);
        check_eq("rst_thresh", 32'(bus.oThreshPoint), 32'd0);
        iRst_n = 1'b1;

        // Frame 1: 1000 identical pixels back to back.
        repeat (260) tick();
        send_run(8'd7, 1000);
        end_frame("f1", rd_at, rd_after);
        check_eq("f1_max", 32'(obs_max), 32'd1000);
        check_bin("f1_bin7", 8'd7, 32'd1000);
        check_bin("f1_bin6", 8'd6, 32'd0);
        check_bin("f1_bin8", 8'd8, 32'd0);
        check_bin("f1_bin255", 8'd255, 32'd0);
        check_eq("f1_overrun", 32'(bus.oOverrun), 32'd0);
        tb_rd_addr = 8'd7;
        repeat (260) tick();

        // Frame 2: 3,3,4,3 pattern hits both forwarding paths.
        for (int i = 0; i < 250; i++) begin
            push(8'd3);
            push(8'd3);
            push(8'd4);
            push(8'd3);
        end
        idle();
        end_frame("f2", rd_at, rd_after);
        check_eq("f2_rd_at_swap", 32'(rd_at), 32'd1000);
        check_eq("f2_rd_after_swap", 32'(rd_after), 32'd0);
        check_eq("f2_max", 32'(obs_max), 32'd750);
        check_bin("f2_bin3", 8'd3, 32'd750);
        check_bin("f2_bin4", 8'd4, 32'd250);
        repeat (260) tick();

        // Frame A: one ramp, then frame B: five nines into the cleared bank.
        for (int i = 0; i < 256; i++) push(8'(i));
        idle();
        end_frame("fa", rd_at, rd_after);
        check_eq("fa_max", 32'(obs_max), 32'd1);
        check_bin("fa_bin200", 8'd200, 32'd1);
        repeat (260) tick();
        send_run(8'd9, 5);
        end_frame("fb", rd_at, rd_after);
        check_eq("fb_max", 32'(obs_max), 32'd5);
        check_bin("fb_bin9", 8'd9, 32'd5);
        check_bin("fb_bin200", 8'd200, 32'd0);
        check_bin("fb_bin3", 8'd3, 32'd0);

        // Pixel and frame end during CLEAR: pixel dropped, frame end ignored.
        push(8'd9);
        idle();
        check_eq("ovr_set", 32'(bus.oOverrun), 32'd1);
        tb_frame_end = 1'b1;
        tick();
        tb_frame_end = 1'b0;
        repeat (260) tick();
        send_run(8'd9, 3);
        end_frame("fo", rd_at, rd_after);
        check_bin("fo_bin9", 8'd9, 32'd3);
        check_eq("fo_max", 32'(obs_max), 32'd3);
        check_eq("fo_overrun_sticky", 32'(bus.oOverrun), 32'd1);
        repeat (260) tick();

        // Mean frame: 100 px of 10 and 100 px of 30.
        send_run(8'd10, 100);
        send_run(8'd30, 100);
        end_frame("fm", rd_at, rd_after);
        check_bin("fm_bin10", 8'd10, 32'd100);
        check_bin("fm_bin30", 8'd30, 32'd100);
        check_eq("fm_max", 32'(obs_max), 32'd100);
        repeat (40) tick();
`ifdef HISTO_MEAN_THRESH_EN
        exp_thresh = 8'd20;
`else
        exp_thresh = 8'd0;
`endif
        check_eq("fm_thresh", 32'(bus.oThreshPoint), 32'(exp_thresh));

        // Saturation on the 10-bit instance: 2**10+5 zeros.
        sel_sat = 1'b1;
        send_run(8'd0, 1029);
        end_frame("fs", rd_at, rd_after);
        check_eq("fs_max", 32'(obs_max), 32'h3FF);
        check_bin("fs_bin0", 8'd0, 32'h3FF);
        check_bin("fs_bin1", 8'd1, 32'd0);
        check_eq("fs_overrun", 32'(bus_s.oOverrun), 32'd0);
        sel_sat = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
